prach_fft_feeder: RTL and testbench
===================================

# prach_fft_feeder

Frame buffer and reorder stage at the input of the PRACH 1536-point FFT. It collects one 1536-sample PRACH symbol in natural order into a ping-pong RAM. It then replays the symbol at one sample per clock in the digit-reversed order that the radix-3/radix-2 DIT FFT consumes, generating that FFT's `din_dv`/`sync_in`. It is the transmitting side of the FFT input interface.

## Interface
- `NUM_FFT_POINTS`, 1536: samples per frame; fixed at 3 × 512, other values unsupported.
- `RAM_LATENCY`, 2: read latency of the frame RAM, address to data, in cycles.

- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `din_dr`  in  16  real part of the input sample, signed.
- `din_di`  in  16  imag part of the input sample, signed.
- `din_dv`  in  1  input sample valid; at most one sample per clock.
- `din_sync`  in  1  marks sample 0 of a frame; only meaningful when `din_dv`=1.
- `dout_dr`  out  16  reordered real sample; drives the FFT `din_dr`.
- `dout_di`  out  16  reordered imag sample.
- `dout_dv`  out  1  output valid; drives the FFT `din_dv`.
- `sync_out`  out  1  one-cycle pulse with output sample 0 of each frame; drives the FFT `sync_in`.
- `err_cnt`  out  8  saturating framing-error count (see Configuration).

## Operation
- RAM: 4096 × 32 bits, simple dual port. The write address is `{wbank, n[10:0]}`, where n is the natural sample index 0..1535.
- Bank state: `full[1:0]`, plus pointers `wbank` and `rbank`.
- Writer FSM:
  - WAIT_SYNC: drops samples with `din_sync`=0. A sample with `din_dv`&`din_sync` writes n=0 and moves to FILL with n=1.
  - FILL: each `din_dv` writes at n, then n++.
    - On writing n=1535: set `full[wbank]`, toggle `wbank`, return to WAIT_SYNC.
    - If `din_dv`&`din_sync` arrives while n≠0 (short frame): increment the error count, rewrite the sample at n=0 of the same bank, continue in FILL with n=1.
  - Samples arriving in WAIT_SYNC without sync also increment the error count, once per dropped run.
  - `din_sync` with `din_dv`=0 is ignored.
- Reader FSM:
  - IDLE: when `full[rbank]`=1, enter READ with r=0, q=0.
  - READ: output position p = 3q + r.
    - Read address = `{rbank, r[1:0], bitrev9(q)}`, i.e. n = 512·r + bitrev9(q).
    - r counts 0,1,2; q increments when r wraps.
    - After p=1535: clear `full[rbank]`, toggle `rbank`. Go back to READ if the new `full[rbank]`=1, else IDLE.
- A writer wrap onto a still-full bank cannot occur: input is at most one sample per clock and readout is one per clock. No overflow path exists.
- `dout_dr`/`dout_di` are 0 whenever `dout_dv`=0.
- Reset, including mid-frame: all partial and buffered frames are discarded, `full`=0, both pointers 0, writer WAIT_SYNC, reader IDLE. All outputs are 0, including `err_cnt`. RAM contents are don't-care.

## Timing
- T = cycle in which the 1536th sample (n=1535) is presented.
- `full` is set at T+1, READ starts at T+1, first read address is issued at T+1.
- `dout_dv`=1 and `sync_out`=1 in cycle T+1+RAM_LATENCY+1 = T+4. Data and valid are registered.
- `dout_dv` stays high for exactly 1536 consecutive cycles, T+4..T+1539. `sync_out` is high only at T+4.
- Back-to-back frames at full input rate: the next frame's output starts 1536 cycles after the previous one, with no gap.
- In all other cases the next frame's output starts at its own T+4.
- The writer and reader never touch the same bank simultaneously.

## Configuration
- `PRACH_FFT_FEEDER_ERR_CNT_EN` defined:
  - `err_cnt` is an 8-bit counter, saturating at 255.
  - It increments once per short frame and once per dropped unsynced run.
  - Cleared only by reset.
- Not defined: `err_cnt` is tied to 0 and no counter logic is built. Framing recovery behaviour is identical in both cases.

## Test plan
- Ramp frame: `din_dr`=n, `din_di`=−n, sync at n=0, contiguous.
  - `sync_out` occurs 4 cycles after n=1535 is presented.
  - Output n sequence: 0, 512, 1024, 256, 768, 1280, 128, …
  - The final output is 1535. Exactly 1536 valids.
- Three back-to-back frames with offsets 0, 2000, 4000 at full rate: three contiguous 1536-sample bursts with no gap, `sync_out` spaced exactly 1536 cycles apart, each frame's data correct.
- Input with `din_dv` toggling 1/0 (half rate):
  - Output burst is still 1536 contiguous valids, starting 4 cycles after the last input sample.
  - `dout_dr`=0 while `dout_dv`=0.
- Sync at n=700, then a full 1536-sample frame: only the second frame is output, and `err_cnt`=1 (macro on) or 0 (macro off).
- 10 samples without sync after reset, then a valid frame: first 10 samples dropped, frame output correct, `err_cnt`=1.
- `rst_n` pulsed low mid-readout (p=800):
  - All outputs 0 immediately.
  - No further valids until a new full frame.
  - A new frame then outputs correctly.

Source files
------------

// File: rtl/prach_fft_feeder.sv
// Ping-pong frame buffer feeding the PRACH 1536-point radix-3/radix-2 FFT in digit-reversed order.
// Optional framing-error counter: define PRACH_FFT_FEEDER_ERR_CNT_EN.
module prach_fft_feeder #(
    parameter int NUM_FFT_POINTS = 1536,
    parameter int RAM_LATENCY    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [15:0] din_dr,
    input  logic signed [15:0] din_di,
    input  logic               din_dv,
    input  logic               din_sync,
    output logic signed [15:0] dout_dr,
    output logic signed [15:0] dout_di,
    output logic               dout_dv,
    output logic               sync_out,
    output logic [7:0]         err_cnt
);
    localparam int STAGES = RAM_LATENCY;
    localparam logic [10:0] LAST_N = 11'(NUM_FFT_POINTS - 1);
    localparam logic [8:0]  LAST_Q = 9'(NUM_FFT_POINTS / 3 - 1);

    typedef enum logic { W_WAIT_SYNC, W_FILL } wr_state_t;
    typedef enum logic { R_IDLE, R_READ } rd_state_t;

    function automatic logic [8:0] bitrev9(input logic [8:0] x);
        logic [8:0] y;
        for (int i = 0; i < 9; i++) y[i] = x[8-i];
        return y;
    endfunction

    logic [31:0] mem [4096];
    logic [31:0] rd_pipe [RAM_LATENCY];
    logic [1:0]  full_q;
    logic        wbank_q, wbank_d, rbank_q, rbank_d;

    // Writer
    wr_state_t   wst_q, wst_d;
    logic [10:0] n_q, n_d, wr_idx;
    logic        wr_en, wr_set;

    always_comb begin
        wst_d   = wst_q;
        n_d     = n_q;
        wbank_d = wbank_q;
        wr_set  = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = n_q;
        if (din_dv) begin
            // A sync always restarts the frame in the current bank, whatever the state.
            if (din_sync) begin
                wr_en  = 1'b1;
                wr_idx = '0;
                wst_d  = W_FILL;
                n_d    = 11'd1;
            end else if (wst_q == W_FILL) begin
                wr_en = 1'b1;
                if (n_q == LAST_N) begin
                    wr_set  = 1'b1;
                    wbank_d = ~wbank_q;
                    wst_d   = W_WAIT_SYNC;
                    n_d     = '0;
                end else begin
                    n_d = n_q + 11'd1;
                end
            end
        end
    end

    // Reader
    rd_state_t  rst_q, rst_d;
    logic [1:0] r_q, r_d;
    logic [8:0] q_q, q_d;
    logic       rd_issue, rd_first, rd_clr;
    logic [11:0] raddr;

    always_comb begin
        rst_d    = rst_q;
        r_d      = r_q;
        q_d      = q_q;
        rbank_d  = rbank_q;
        rd_clr   = 1'b0;
        // Starting straight from IDLE keeps back-to-back frames gapless; r/q are 0 there.
        rd_issue = (rst_q == R_READ) || full_q[rbank_q];
        rd_first = rd_issue && (r_q == 2'd0) && (q_q == 9'd0);
        if (rd_issue) begin
            rst_d = R_READ;
            if (r_q == 2'd2) begin
                r_d = 2'd0;
                q_d = q_q + 9'd1;
            end else begin
                r_d = r_q + 2'd1;
            end
            if (r_q == 2'd2 && q_q == LAST_Q) begin
                rd_clr  = 1'b1;
                rbank_d = ~rbank_q;
                rst_d   = full_q[~rbank_q] ? R_READ : R_IDLE;
            end
        end
    end

    assign raddr = {rbank_q, r_q, bitrev9(q_q)};

    always_ff @(posedge clk) begin
        if (wr_en) mem[{wbank_q, wr_idx}] <= {din_dr, din_di};
        rd_pipe[0] <= mem[raddr];
        for (int i = 1; i < RAM_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    logic [STAGES:0] vld_pipe, sync_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wst_q     <= W_WAIT_SYNC;
            n_q       <= '0;
            wbank_q   <= 1'b0;
            rst_q     <= R_IDLE;
            r_q       <= '0;
            q_q       <= '0;
            rbank_q   <= 1'b0;
            full_q    <= '0;
            vld_pipe  <= '0;
            sync_pipe <= '0;
            dout_dr   <= '0;
            dout_di   <= '0;
        end else begin
            wst_q     <= wst_d;
            n_q       <= n_d;
            wbank_q   <= wbank_d;
            rst_q     <= rst_d;
            r_q       <= r_d;
            q_q       <= q_d;
            rbank_q   <= rbank_d;
            if (wr_set) full_q[wbank_q] <= 1'b1;
            if (rd_clr) full_q[rbank_q] <= 1'b0;
            vld_pipe  <= {vld_pipe[STAGES-1:0], rd_issue};
            sync_pipe <= {sync_pipe[STAGES-1:0], rd_first};
            if (vld_pipe[STAGES-1]) begin
                dout_dr <= rd_pipe[RAM_LATENCY-1][31:16];
                dout_di <= rd_pipe[RAM_LATENCY-1][15:0];
            end else begin
                dout_dr <= '0;
                dout_di <= '0;
            end
        end
    end

    assign dout_dv  = vld_pipe[STAGES];
    assign sync_out = sync_pipe[STAGES];

`ifdef PRACH_FFT_FEEDER_ERR_CNT_EN
    logic       dropping_q, err_inc;
    logic [7:0] err_q;

    // One count per short frame, and one per run of unsynced samples in WAIT_SYNC.
    assign err_inc = din_dv && ((din_sync && wst_q == W_FILL) ||
                                (!din_sync && wst_q == W_WAIT_SYNC && !dropping_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dropping_q <= 1'b0;
            err_q      <= '0;
        end else begin
            if (din_dv && wst_q == W_WAIT_SYNC) dropping_q <= !din_sync;
            if (err_inc && err_q != 8'hFF) err_q <= err_q + 8'd1;
        end
    end

    assign err_cnt = err_q;
`else
    assign err_cnt = '0;
`endif
endmodule

// File: tb/tb_prach_fft_feeder.sv
// Directed bench for prach_fft_feeder: ordering table, burst timing, framing recovery and reset.
module tb_prach_fft_feeder;
`ifdef PRACH_FFT_FEEDER_ERR_CNT_EN
    localparam int EXP_ERR = 1;
`else
    localparam int EXP_ERR = 0;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [15:0] din_dr = '0, din_di = '0;
    logic               din_dv = 1'b0, din_sync = 1'b0;
    logic signed [15:0] dout_dr, dout_di;
    logic               dout_dv, sync_out;
    logic [7:0]         err_cnt;

    prach_fft_feeder dut (
        .clk(clk), .rst_n(rst_n),
        .din_dr(din_dr), .din_di(din_di), .din_dv(din_dv), .din_sync(din_sync),
        .dout_dr(dout_dr), .dout_di(dout_di), .dout_dv(dout_dv), .sync_out(sync_out),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic signed [15:0] cap_dr[$], cap_di[$];
    int cap_cyc[$], sync_cyc[$];
    int zero_bad = 0;

    always @(negedge clk) begin
        if (dout_dv) begin
            cap_dr.push_back(dout_dr);
            cap_di.push_back(dout_di);
            cap_cyc.push_back(cyc);
        end else if (dout_dr != 0 || dout_di != 0) begin
            zero_bad++;
        end
        if (sync_out) sync_cyc.push_back(cyc);
    end

    int errors = 0, checks = 0;
    int last_t;

    typedef struct { int p; int exp_n; } vec_t;
    vec_t vecs[12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_n(input int p);
        int r, q, br;
        r  = p % 3;
        q  = p / 3;
        br = 0;
        for (int i = 0; i < 9; i++) if (q[i]) br |= (1 << (8 - i));
        return 512 * r + br;
    endfunction

    function automatic int get_dr(input int idx);
        return (idx < cap_dr.size()) ? int'(cap_dr[idx]) : -99999;
    endfunction
    function automatic int get_di(input int idx);
        return (idx < cap_di.size()) ? int'(cap_di[idx]) : -99999;
    endfunction
    function automatic int get_q(input int idx, input bit is_sync);
        if (is_sync) return (idx < sync_cyc.size()) ? sync_cyc[idx] : -99999;
        return (idx < cap_cyc.size()) ? cap_cyc[idx] : -99999;
    endfunction

    function automatic int frame_bad(input int base, input int off);
        int bad = 0;
        for (int p = 0; p < 1536; p++) begin
            if (get_dr(base + p) != off + exp_n(p) || get_di(base + p) != -(off + exp_n(p)))
                bad++;
        end
        return bad;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0; din_dv = 1'b0; din_sync = 1'b0; din_dr = '0; din_di = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic send(input int off, input int cnt, input bit sync_first, input bit half);
        for (int i = 0; i < cnt; i++) begin
            @(posedge clk); #1;
            din_dv   = 1'b1;
            din_sync = (i == 0) && sync_first;
            din_dr   = 16'(off + i);
            din_di   = 16'(-(off + i));
            last_t   = cyc;
            if (half) begin
                @(posedge clk); #1;
                din_dv = 1'b0; din_sync = 1'b0;
            end
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        din_dv = 1'b0; din_sync = 1'b0; din_dr = '0; din_di = '0;
    endtask

    task automatic wait_caps(input int target, input int budget);
        int k = 0;
        while (cap_dr.size() < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        repeat (20) @(negedge clk);
    endtask

    initial begin
        int b, s, z, t1;
        vecs = '{'{0, 0}, '{1, 512}, '{2, 1024}, '{3, 256}, '{4, 768}, '{5, 1280},
                 '{6, 128}, '{7, 640}, '{9, 384}, '{1533, 511}, '{1534, 1023}, '{1535, 1535}};

        do_reset();
        chk("reset dout_dv", dout_dv, 0);
        chk("reset sync_out", sync_out, 0);
        chk("reset dout_dr", dout_dr, 0);
        chk("reset err_cnt", err_cnt, 0);

        // Ramp frame and the ordering table
        b = cap_dr.size(); s = sync_cyc.size(); z = zero_bad;
        send(0, 1536, 1'b1, 1'b0);
        idle();
        wait_caps(b + 1536, 3000);
        chk("ramp valid count", cap_dr.size() - b, 1536);
        chk("ramp sync count", sync_cyc.size() - s, 1);
        chk("ramp sync latency", get_q(s, 1'b1) - last_t, 4);
        chk("ramp contiguous", get_q(b + 1535, 1'b0) - get_q(b, 1'b0), 1535);
        chk("ramp zero when idle", zero_bad - z, 0);
        foreach (vecs[i]) begin
            chk($sformatf("ramp p%0d dr", vecs[i].p), get_dr(b + vecs[i].p), vecs[i].exp_n);
            chk($sformatf("ramp p%0d di", vecs[i].p), get_di(b + vecs[i].p), -vecs[i].exp_n);
        end

        // Three back-to-back frames at full rate
        do_reset();
        b = cap_dr.size(); s = sync_cyc.size();
        send(0, 1536, 1'b1, 1'b0);
        t1 = last_t;
        send(2000, 1536, 1'b1, 1'b0);
        send(4000, 1536, 1'b1, 1'b0);
        idle();
        wait_caps(b + 4608, 8000);
        chk("b2b valid count", cap_dr.size() - b, 4608);
        chk("b2b sync count", sync_cyc.size() - s, 3);
        chk("b2b first latency", get_q(s, 1'b1) - t1, 4);
        chk("b2b sync spacing 1", get_q(s + 1, 1'b1) - get_q(s, 1'b1), 1536);
        chk("b2b sync spacing 2", get_q(s + 2, 1'b1) - get_q(s + 1, 1'b1), 1536);
        chk("b2b contiguous", get_q(b + 4607, 1'b0) - get_q(b, 1'b0), 4607);
        chk("b2b frame0 bad samples", frame_bad(b, 0), 0);
        chk("b2b frame1 bad samples", frame_bad(b + 1536, 2000), 0);
        chk("b2b frame2 bad samples", frame_bad(b + 3072, 4000), 0);

        // Half-rate input
        do_reset();
        b = cap_dr.size(); z = zero_bad;
        send(0, 1536, 1'b1, 1'b1);
        idle();
        wait_caps(b + 1536, 3000);
        chk("half valid count", cap_dr.size() - b, 1536);
        chk("half start latency", get_q(b, 1'b0) - last_t, 4);
        chk("half contiguous", get_q(b + 1535, 1'b0) - get_q(b, 1'b0), 1535);
        chk("half zero when idle", zero_bad - z, 0);
        chk("half bad samples", frame_bad(b, 0), 0);

        // Short frame (resync at n=700)
        do_reset();
        b = cap_dr.size();
        send(0, 700, 1'b1, 1'b0);
        send(3000, 1536, 1'b1, 1'b0);
        idle();
        wait_caps(b + 1536, 3000);
        repeat (200) @(negedge clk);
        chk("short valid count", cap_dr.size() - b, 1536);
        chk("short bad samples", frame_bad(b, 3000), 0);
        chk("short err_cnt", err_cnt, EXP_ERR);

        // Unsynced run then a good frame
        do_reset();
        b = cap_dr.size();
        send(100, 10, 1'b0, 1'b0);
        send(200, 1536, 1'b1, 1'b0);
        idle();
        wait_caps(b + 1536, 3000);
        repeat (200) @(negedge clk);
        chk("unsync valid count", cap_dr.size() - b, 1536);
        chk("unsync bad samples", frame_bad(b, 200), 0);
        chk("unsync err_cnt", err_cnt, EXP_ERR);

        // Reset in the middle of readout
        do_reset();
        b = cap_dr.size();
        send(500, 1536, 1'b1, 1'b0);
        idle();
        begin
            int k = 0;
            while (cap_dr.size() < b + 801 && k < 3000) begin
                @(negedge clk);
                k++;
            end
        end
        chk("midrst reached p800", (cap_dr.size() - b >= 801) ? 1 : 0, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst dout_dv", dout_dv, 0);
        chk("midrst sync_out", sync_out, 0);
        chk("midrst dout_dr", dout_dr, 0);
        chk("midrst dout_di", dout_di, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        b = cap_dr.size();
        repeat (2000) @(negedge clk);
        chk("midrst no valids", cap_dr.size() - b, 0);
        send(700, 1536, 1'b1, 1'b0);
        idle();
        wait_caps(b + 1536, 3000);
        chk("midrst new count", cap_dr.size() - b, 1536);
        chk("midrst new bad samples", frame_bad(b, 700), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
